// File: rtl/rf_wr_arbiter_pkg.sv
// Shared processor package for the register-file write arbiter.
// Provides the default datapath sizes and the writeback source enum.
package rf_wr_arbiter_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);

  // Writeback sources competing for the single register-file write port
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage : rf_wr_arbiter_pkg

// File: rtl/rf_wr_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holding register (full flag, dest reg, data).
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   load          - capture reg_in/data_in and mark full (wins over clear)
//   clear         - entry was written this cycle; empty it at the next edge
//   reg_in/data_in- incoming destination register and write data
//   full          - entry holds an unwritten write
//   slot_reg      - held destination register
//   slot_data     - held write data
module wb_slot #(
  parameter int unsigned DATA_W = rf_wr_arbiter_pkg::DATA_W,
  parameter int unsigned REG_AW = rf_wr_arbiter_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [REG_AW-1:0] reg_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic [REG_AW-1:0] slot_reg,
  output logic [DATA_W-1:0] slot_data
);

  import rf_wr_arbiter_pkg::*;

  logic              full_q, full_d;
  logic [REG_AW-1:0] reg_q,  reg_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-entry: a load in the same cycle as a clear keeps the slot full
  always_comb begin
    full_d = full_q;
    reg_d  = reg_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      reg_d  = reg_in;
      data_d = data_in;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  // Entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign full      = full_q;
  assign slot_reg  = reg_q;
  assign slot_data = data_q;

endmodule : wb_slot

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: arbitrates ALU and load-return writebacks onto one
// register-file write port. Each source owns a one-entry slot; when both
// slots are full the one loaded earlier wins (MEM on a same-edge tie).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   alu_valid/alu_reg/alu_data     - ALU writeback request, alu_ready accept
//   mem_valid/mem_reg/mem_data     - load writeback request, mem_ready accept
//   wr_en/wr_reg/wr_data           - register-file write port (from slots only)
//   pending                        - per-register "held write outstanding" map
module rf_wr_arbiter #(
  parameter int unsigned DATA_W   = rf_wr_arbiter_pkg::DATA_W,
  parameter int unsigned NUM_REGS = rf_wr_arbiter_pkg::NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [$clog2(NUM_REGS)-1:0] alu_reg,
  input  logic [DATA_W-1:0]           alu_data,
  output logic                        alu_ready,
  input  logic                        mem_valid,
  input  logic [$clog2(NUM_REGS)-1:0] mem_reg,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        mem_ready,
  output logic                        wr_en,
  output logic [$clog2(NUM_REGS)-1:0] wr_reg,
  output logic [DATA_W-1:0]           wr_data,
  output logic [NUM_REGS-1:0]         pending
);

  import rf_wr_arbiter_pkg::*;

  localparam int unsigned REG_AW = $clog2(NUM_REGS);

  logic              alu_full, mem_full;
  logic [REG_AW-1:0] alu_reg_q, mem_reg_q;
  logic [DATA_W-1:0] alu_data_q, mem_data_q;
  logic              grant_alu, grant_mem;
  logic              alu_load, mem_load;
  src_e              wr_src;

  // High when the ALU entry was loaded strictly before the MEM entry
  logic              alu_older_q, alu_older_d;

  wb_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_alu_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (alu_load),
    .clear     (grant_alu),
    .reg_in    (alu_reg),
    .data_in   (alu_data),
    .full      (alu_full),
    .slot_reg  (alu_reg_q),
    .slot_data (alu_data_q)
  );

  wb_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mem_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (mem_load),
    .clear     (grant_mem),
    .reg_in    (mem_reg),
    .data_in   (mem_data),
    .full      (mem_full),
    .slot_reg  (mem_reg_q),
    .slot_data (mem_data_q)
  );

  // Grant: sole full slot, otherwise the older one; nothing during reset
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (alu_full && mem_full) begin
        grant_alu = alu_older_q;
        grant_mem = ~alu_older_q;
      end else begin
        grant_alu = alu_full;
        grant_mem = mem_full;
      end
    end
  end

  // A slot can accept when empty or when it is draining this cycle
  always_comb begin
    alu_ready = ~rst & (~alu_full | grant_alu);
    mem_ready = ~rst & (~mem_full | grant_mem);
    alu_load  = alu_valid & alu_ready;
    mem_load  = mem_valid & mem_ready;
  end

  // Age: a freshly loaded slot is always younger than a held one; a
  // same-edge double load leaves MEM as the older entry.
  always_comb begin
    alu_older_d = alu_older_q;
    if (alu_load && mem_load) begin
      alu_older_d = 1'b0;
    end else if (alu_load) begin
      alu_older_d = 1'b0;
    end else if (mem_load) begin
      alu_older_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_older_q <= 1'b0;
    end else begin
      alu_older_q <= alu_older_d;
    end
  end

  // Write port muxed from slot registers only; zeroed when idle
  always_comb begin
    wr_src  = grant_mem ? SRC_MEM : SRC_ALU;
    wr_en   = grant_alu | grant_mem;
    wr_reg  = '0;
    wr_data = '0;
    if (wr_en) begin
      case (wr_src)
        SRC_MEM: begin
          wr_reg  = mem_reg_q;
          wr_data = mem_data_q;
        end
        default: begin
          wr_reg  = alu_reg_q;
          wr_data = alu_data_q;
        end
      endcase
    end
  end

  // Pending-register decode; forced clear while in reset
  always_comb begin
    pending = '0;
    if (!rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        pending[r] = (alu_full && (alu_reg_q == REG_AW'(r))) ||
                     (mem_full && (mem_reg_q == REG_AW'(r)));
      end
    end
  end

endmodule : rf_wr_arbiter

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register write-data width.
REQ-002 SHALL have parameter NUM_REGS, default 8, architectural register count; REG_AW = log2(NUM_REGS) = 3.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port alu_valid  in  1  ALU/immediate writeback request.
REQ-006 SHALL have port alu_reg  in  REG_AW  ALU destination register.
REQ-007 SHALL have port alu_data  in  DATA_W  ALU result.
REQ-008 SHALL have port alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
REQ-009 SHALL have port mem_valid  in  1  load-return writeback request from multicycle memory.
REQ-010 SHALL have port mem_reg  in  REG_AW  load destination register.
REQ-011 SHALL have port mem_data  in  DATA_W  load data.
REQ-012 SHALL have port mem_ready  out  1  load request accepted this cycle when high with mem_valid.
REQ-013 SHALL have port wr_en  out  1  register-file write enable.
REQ-014 SHALL have port wr_reg  out  REG_AW  register-file write address.
REQ-015 SHALL have port wr_data  out  DATA_W  register-file write data.
REQ-016 SHALL have port pending  out  NUM_REGS  bit r high while a held, unwritten write targets register r.

Function
REQ-017 SHALL hold one entry per source (ALU slot, MEM slot): full flag, reg, data, load-order age.
REQ-018 SHALL accept on valid & ready; accepted entry loads its slot at that clock edge.
REQ-019 SHALL drive x_ready = ~full_x | grant_x (slot may drain and reload in same cycle); x_ready = 0 while rst high.
REQ-020 SHALL grant at most one slot per cycle; only a full slot may be granted.
REQ-021 SHALL grant the sole full slot when exactly one is full.
REQ-022 SHALL, when both are full, grant the slot loaded earlier; if both loaded on the same edge, grant MEM (load is the older instruction).
REQ-023 SHALL drive wr_en = grant_alu | grant_mem, and wr_reg/wr_data from the granted slot, combinationally from slot registers only (no input-to-output path).
REQ-024 SHALL give latency: request accepted at edge N produces wr_en in cycle N+1 if uncontested, N+2 if it loses one arbitration; never more than N+2.
REQ-025 SHALL clear a granted slot at the next edge unless reloaded by a same-cycle accept.
REQ-026 SHALL treat a reloaded slot as younger than the other held slot (no starvation).
REQ-027 SHALL preserve order for same-register writes: older entry writes first, younger next cycle.
REQ-028 SHALL drive pending[r] = (full_alu & alu_reg_q == r) | (full_mem & mem_reg_q == r).
REQ-029 SHALL drive wr_reg = 0, wr_data = 0 when wr_en = 0.

Reset
REQ-030 SHALL on rst clear both full flags and age; wr_en = 0, wr_reg = 0, wr_data = 0, pending = 0, both ready = 0.
REQ-031 SHALL drop any held entry when rst asserts mid-operation; no write occurs in the cycle after rst deasserts.
REQ-032 SHALL assert both ready in the first cycle after rst deasserts.

Structure
REQ-033 SHALL take DATA_W, NUM_REGS, REG_AW and the source enum {SRC_ALU, SRC_MEM} from the shared processor package.
REQ-034 SHALL implement each holding slot as sub-module wb_slot (full/reg/data register with load, clear, load-over-clear), instantiated twice.
REQ-035 SHALL keep arbitration, age tracking and pending decode in rf_wr_arbiter.

Verification
REQ-036 SHALL cover: ALU only, alu_reg=3, alu_data=0x1234 at edge 1 -> cycle 2 wr_en=1, wr_reg=3, wr_data=0x1234; pending[3]=1 in cycle 2 only.
REQ-037 SHALL cover: ALU (r2,0xAAAA) and MEM (r5,0x5555) same edge -> cycle N+1 writes r5/0x5555, cycle N+2 writes r2/0xAAAA.
REQ-038 SHALL cover: MEM held, ALU held older, MEM reloads each cycle with mem_valid=1 for 4 cycles -> grants alternate ALU/MEM; no slot waits more than one cycle.
REQ-039 SHALL cover: ALU (r1,0x0001) then MEM (r1,0x0002) next edge while ALU slot blocked -> r1 written 0x0001 then 0x0002, final value 0x0002.
REQ-040 SHALL cover: both slots full, rst pulsed one cycle -> no write after reset, pending=0x00, both ready=1 in first cycle post-reset.
